// File: rtl/button_debouncer_if.sv
// Button-side bundle for the debouncer: raw pins in, debounced level and event pulses out.
// The master drives the pins (board or bench); the debouncer sits on the slave side.
interface button_debouncer_if #(
  parameter int NUM_BUTTONS = 4
);
  logic [NUM_BUTTONS-1:0] btn_in;
  logic [NUM_BUTTONS-1:0] btn_state;
  logic [NUM_BUTTONS-1:0] btn_press;
  logic [NUM_BUTTONS-1:0] btn_release;
  logic [NUM_BUTTONS-1:0] btn_hold;

  modport master (
    output btn_in,
    input  btn_state,
    input  btn_press,
    input  btn_release,
    input  btn_hold
  );

  modport slave (
    input  btn_in,
    output btn_state,
    output btn_press,
    output btn_release,
    output btn_hold
  );
endinterface

// File: rtl/button_debouncer.sv
// Debounces NUM_BUTTONS independent pushbuttons and reports a clean level plus
// press, release and one-shot long-hold pulses per channel.
module button_debouncer #(
  parameter int               NUM_BUTTONS     = 4,
  parameter int               CNT_W           = 25,
  parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 25'd640000,
  parameter logic [CNT_W-1:0] HOLD_CYCLES     = 25'd32000000,
  parameter bit               ACTIVE_LOW      = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  button_debouncer_if.slave bus
);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] DBC_LAST  = DEBOUNCE_CYCLES - 1'b1;
  localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_CYCLES - 1'b1;

  logic [NUM_BUTTONS-1:0] r_sync1;
  logic [NUM_BUTTONS-1:0] r_sync2;
  logic [NUM_BUTTONS-1:0] w_raw;
  logic [NUM_BUTTONS-1:0] w_state;
  logic [NUM_BUTTONS-1:0] w_press;
  logic [NUM_BUTTONS-1:0] w_release;
  logic [NUM_BUTTONS-1:0] w_hold;

  // Synchronizer presets to the idle pin level so leaving reset never looks like a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= {NUM_BUTTONS{ACTIVE_LOW}};
      r_sync2 <= {NUM_BUTTONS{ACTIVE_LOW}};
    end else begin
      r_sync1 <= bus.btn_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_raw = ACTIVE_LOW ? ~r_sync2 : r_sync2;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
    state_t           r_state;
    logic [CNT_W-1:0] r_dbc;
    logic [CNT_W-1:0] r_hld;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             r_hold;

    // The hold counter freezes during a pending release so a bounce resumes rather than restarts it.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state   <= RELEASED;
        r_dbc     <= '0;
        r_hld     <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_hold    <= 1'b0;
      end else begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_hold    <= 1'b0;
        case (r_state)
          RELEASED: begin
            if (w_raw[g]) begin
              r_state <= PRESS_WAIT;
              r_dbc   <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!w_raw[g]) begin
              r_state <= RELEASED;
            end else if (r_dbc == DBC_LAST) begin
              r_state <= PRESSED;
              r_level <= 1'b1;
              r_press <= 1'b1;
              r_hld   <= '0;
            end else begin
              r_dbc <= r_dbc + 1'b1;
            end
          end
          PRESSED: begin
            if (!w_raw[g]) begin
              r_state <= RELEASE_WAIT;
              r_dbc   <= '0;
            end else if (r_hld < HOLD_CYCLES) begin
              r_hld <= r_hld + 1'b1;
              if (r_hld == HOLD_LAST) begin
                r_hold <= 1'b1;
              end
            end
          end
          RELEASE_WAIT: begin
            if (w_raw[g]) begin
              r_state <= PRESSED;
            end else if (r_dbc == DBC_LAST) begin
              r_state   <= RELEASED;
              r_level   <= 1'b0;
              r_release <= 1'b1;
            end else begin
              r_dbc <= r_dbc + 1'b1;
            end
          end
          default: begin
            r_state <= RELEASED;
          end
        endcase
      end
    end

    assign w_state[g]   = r_level;
    assign w_press[g]   = r_press;
    assign w_release[g] = r_release;
    assign w_hold[g]    = r_hold;
  end

  assign bus.btn_state   = w_state;
  assign bus.btn_press   = w_press;
  assign bus.btn_release = w_release;
  assign bus.btn_hold    = w_hold;

endmodule

// File: tb/tb_button_debouncer.sv
// Randomised and directed bench for button_debouncer; a run-length reference model
// feeds an event scoreboard that a separate monitor drains against the DUT pulses.
module tb_button_debouncer;

  localparam int NB   = 2;
  localparam int DBC  = 4;
  localparam int HOLD = 10;

  typedef struct {
    int           cyc;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
    logic [NB-1:0] hold;
  } ev_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   cyc;
  int   pressCyc0;
  int   holdCyc0;
  ev_t  expQ[$];
  ev_t  gotEv;
  logic anyPulse;

  // Reference model: a level flips once the synchronised sample has disagreed with it DBC+1 times in a row.
  logic [NB-1:0] hist[2];
  logic [NB-1:0] expState;
  logic [NB-1:0] prevRaw;
  int            run[NB];
  int            hcnt[NB];

  button_debouncer_if #(.NUM_BUTTONS(NB)) bus ();

  button_debouncer #(
    .NUM_BUTTONS    (NB),
    .CNT_W          (25),
    .DEBOUNCE_CYCLES(25'd4),
    .HOLD_CYCLES    (25'd10),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic modelReset();
    hist[0]  = '0;
    hist[1]  = '0;
    expState = '0;
    prevRaw  = '0;
    for (int ch = 0; ch < NB; ch++) begin
      run[ch]  = 0;
      hcnt[ch] = 0;
    end
    expQ.delete();
  endtask

  task automatic modelStep(input logic [NB-1:0] pins);
    ev_t           e;
    logic [NB-1:0] rawNow;
    rawNow  = hist[0];
    hist[0] = hist[1];
    hist[1] = ~pins;
    e.cyc   = cyc;
    e.press = '0;
    e.rel   = '0;
    e.hold  = '0;
    for (int ch = 0; ch < NB; ch++) begin
      if (rawNow[ch] != expState[ch]) run[ch]++;
      else run[ch] = 0;
      if (run[ch] == DBC + 1) begin
        expState[ch] = rawNow[ch];
        run[ch]      = 0;
        if (rawNow[ch]) begin
          e.press[ch] = 1'b1;
          hcnt[ch]    = 0;
        end else begin
          e.rel[ch] = 1'b1;
        end
      end else if (expState[ch] && rawNow[ch] && prevRaw[ch] && hcnt[ch] < HOLD) begin
        hcnt[ch]++;
        if (hcnt[ch] == HOLD) e.hold[ch] = 1'b1;
      end
      prevRaw[ch] = rawNow[ch];
    end
    if (|{e.press, e.rel, e.hold}) expQ.push_back(e);
  endtask

  // One clock: advance the model on what the DUT samples at this edge, then drive the next inputs.
  task automatic applyStimulus(input logic [NB-1:0] pins, input logic rstVal);
    @(posedge clk);
    cyc++;
    if (reset) modelReset();
    else modelStep(bus.btn_in);
    #2;
    bus.btn_in = pins;
    reset      = rstVal;
    if (rstVal) modelReset();
  endtask

  always @(negedge clk) begin
    if (reset) begin
      checkOutput("reset_outputs",
                  int'({bus.btn_state, bus.btn_press, bus.btn_release, bus.btn_hold}), 0);
    end else begin
      anyPulse = |{bus.btn_press, bus.btn_release, bus.btn_hold};
      if (anyPulse) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_pulse",
                      int'({bus.btn_press, bus.btn_release, bus.btn_hold}), 0);
        end else begin
          gotEv = expQ.pop_front();
          checkOutput("pulse_cycle", cyc, gotEv.cyc);
          checkOutput("pulse_vectors",
                      int'({bus.btn_press, bus.btn_release, bus.btn_hold}),
                      int'({gotEv.press, gotEv.rel, gotEv.hold}));
        end
      end else if (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
        gotEv = expQ.pop_front();
        checkOutput("missing_pulse", 0, int'({gotEv.press, gotEv.rel, gotEv.hold}));
      end
      checkOutput("btn_state", int'(bus.btn_state), int'(expState));
      if (bus.btn_press[0]) pressCyc0 = cyc;
      if (bus.btn_hold[0])  holdCyc0  = cyc;
    end
  end

  initial begin
    int c0;
    int len;
    logic [NB-1:0] pins;
    checks     = 0;
    failures   = 0;
    cyc        = 0;
    pressCyc0  = -1;
    holdCyc0   = -1;
    reset      = 1'b1;
    bus.btn_in = 2'b11;
    modelReset();

    // Long reset with pins idle.
    repeat (20) applyStimulus(2'b11, 1'b1);
    repeat (5) applyStimulus(2'b11, 1'b0);

    // Single press held long enough for exactly one hold pulse.
    pressCyc0 = -1;
    holdCyc0  = -1;
    applyStimulus(2'b10, 1'b0);
    c0 = cyc;
    repeat (35) applyStimulus(2'b10, 1'b0);
    checkOutput("press_latency", pressCyc0, c0 + DBC + 3);
    checkOutput("hold_latency", holdCyc0, c0 + DBC + 3 + HOLD);
    repeat (15) applyStimulus(2'b11, 1'b0);

    // Short glitches on channel 0 must be rejected.
    repeat (3) applyStimulus(2'b10, 1'b0);
    repeat (4) applyStimulus(2'b11, 1'b0);
    for (int k = 0; k < 10; k++) begin
      repeat ($urandom_range(1, 3)) applyStimulus(2'b10, 1'b0);
      repeat ($urandom_range(1, 4)) applyStimulus(2'b11, 1'b0);
    end
    repeat (10) applyStimulus(2'b11, 1'b0);

    // Short press, bouncy release.
    repeat (12) applyStimulus(2'b10, 1'b0);
    repeat (2) applyStimulus(2'b11, 1'b0);
    repeat (2) applyStimulus(2'b10, 1'b0);
    repeat (15) applyStimulus(2'b11, 1'b0);

    // Simultaneous press, then release channel 1 alone.
    repeat (15) applyStimulus(2'b00, 1'b0);
    repeat (15) applyStimulus(2'b01, 1'b0);
    repeat (15) applyStimulus(2'b11, 1'b0);

    // Reset while pressed, pin still held afterwards.
    repeat (12) applyStimulus(2'b10, 1'b0);
    repeat (3) applyStimulus(2'b10, 1'b1);
    pressCyc0 = -1;
    applyStimulus(2'b10, 1'b0);
    c0 = cyc;
    repeat (12) applyStimulus(2'b10, 1'b0);
    checkOutput("press_after_reset", pressCyc0, c0 + DBC + 3);
    repeat (15) applyStimulus(2'b11, 1'b0);

    // Random run lengths on both channels.
    for (int k = 0; k < 40; k++) begin
      pins = NB'($urandom);
      len  = $urandom_range(1, 20);
      repeat (len) applyStimulus(pins, 1'b0);
    end
    repeat (25) applyStimulus(2'b11, 1'b0);

    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
